// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: arbiter FSM encodings, the
// default watchdog limit matched to tx_ctl's slowest baud, and a width helper.
package uart_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int unsigned TX_TIMEOUT_DEFAULT = 32'd100000;

   // Ceiling log2, clamped to 1 so a derived vector width is always legal.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 32'd1;
      for (int unsigned i = 32'd1; i < 32'd32; i++) begin
         if ((32'd1 << i) < value) begin
            width = i + 32'd1;
         end
      end
      return width;
   endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first asserted request strictly after
// last_i, wrapping NREQ-1 -> 0, so last_i itself has the lowest priority.
module rr_arb_pick
   import uart_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_i,
   output logic            valid_o,
   output logic [IDW-1:0]  winner_o
);

   int unsigned      cand;
   logic [IDW-1:0]   cand_idx;

   // Scan from furthest to nearest candidate so the nearest one overwrites last.
   always_comb begin
      winner_o = '0;
      cand     = 32'd0;
      cand_idx = '0;
      for (int unsigned k = NREQ; k >= 32'd1; k--) begin
         cand     = (32'(last_i) + k) % NREQ;
         cand_idx = IDW'(cand);
         winner_o = req_i[cand_idx] ? cand_idx : winner_o;
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of the single UART transmit datapath between NREQ byte
// requesters, with inter-frame gap and a watchdog against a stuck tx_ctl.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned GAP_CYCLES = 1,
   parameter int unsigned TIMEOUT    = TX_TIMEOUT_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*8-1:0]      req_data,
   output logic [NREQ-1:0]        ack,
   output logic [clog2(NREQ)-1:0] grant_id,
   output logic                   tx_en_sig,
   output logic [7:0]             tx_data,
   input  logic                   tx_done_sig,
   output logic                   busy,
   output logic                   timeout_err
);

   localparam int unsigned IDW = clog2(NREQ);
   localparam int unsigned WDW = clog2(TIMEOUT + 32'd1);
   localparam int unsigned GCW = clog2(GAP_CYCLES + 32'd1);

   localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 32'd1);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 32'd1);
   localparam logic [IDW-1:0] LAST_RST  = IDW'(NREQ - 32'd1);

   logic [1:0]      state_q,   state_d;
   logic [IDW-1:0]  last_q,    last_d;
   logic [WDW-1:0]  wdog_q,    wdog_d;
   logic [GCW-1:0]  gap_q,     gap_d;
   logic            tx_en_q,   tx_en_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic [IDW-1:0]  grant_q,   grant_d;
   logic [NREQ-1:0] ack_q,     ack_d;
   logic            err_q,     err_d;
   logic            busy_q,    busy_d;

   logic            pick_valid;
   logic [IDW-1:0]  pick_winner;

   rr_arb_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i    (req),
      .last_i   (last_q),
      .valid_o  (pick_valid),
      .winner_o (pick_winner)
   );

   // Next-state and next-output computation for the IDLE/SEND/GAP sequence.
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      wdog_d    = wdog_q;
      gap_d     = gap_q;
      tx_en_d   = tx_en_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      ack_d     = '0;
      err_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               tx_data_d = req_data[{pick_winner, 3'b000} +: 8];
               grant_d   = pick_winner;
               ack_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_winner;
               tx_en_d   = 1'b1;
               wdog_d    = '0;
               state_d   = ST_SEND;
            end else begin
               tx_en_d   = 1'b0;
            end
         end
         ST_SEND: begin
            // Completion takes precedence over a watchdog expiring on the same cycle.
            if (tx_done_sig) begin
               tx_en_d = 1'b0;
               last_d  = grant_q;
               gap_d   = '0;
               state_d = ST_GAP;
            end else if (wdog_q == WDOG_LAST) begin
               tx_en_d = 1'b0;
               err_d   = 1'b1;
               last_d  = grant_q;
               gap_d   = '0;
               state_d = ST_GAP;
            end else begin
               wdog_d  = wdog_q + WDW'(1'b1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d   = gap_q + GCW'(1'b1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_en_d = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         last_q    <= LAST_RST;
         wdog_q    <= '0;
         gap_q     <= '0;
         tx_en_q   <= 1'b0;
         tx_data_q <= 8'h00;
         grant_q   <= '0;
         ack_q     <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         wdog_q    <= wdog_d;
         gap_q     <= gap_d;
         tx_en_q   <= tx_en_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   assign ack         = ack_q;
   assign grant_id    = grant_q;
   assign tx_en_sig   = tx_en_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;

endmodule
